// File: rtl/mips_alu_pkg.sv
// Shared ALU operation codes plus MIPS opcode/funct constants used by the
// issue stage and the ALU.
package mips_alu_pkg;

    typedef logic [4:0] alu_sel_t;

    localparam alu_sel_t ALU_NOP   = 5'd0;
    localparam alu_sel_t ALU_ADD   = 5'd1;
    localparam alu_sel_t ALU_ADDU  = 5'd2;
    localparam alu_sel_t ALU_SUB   = 5'd3;
    localparam alu_sel_t ALU_SUBU  = 5'd4;
    localparam alu_sel_t ALU_AND   = 5'd5;
    localparam alu_sel_t ALU_OR    = 5'd6;
    localparam alu_sel_t ALU_XOR   = 5'd7;
    localparam alu_sel_t ALU_NOR   = 5'd8;
    localparam alu_sel_t ALU_SLT   = 5'd9;
    localparam alu_sel_t ALU_SLTU  = 5'd10;
    localparam alu_sel_t ALU_ADDI  = 5'd11;
    localparam alu_sel_t ALU_ADDIU = 5'd12;
    localparam alu_sel_t ALU_SLTI  = 5'd13;
    localparam alu_sel_t ALU_SLTIU = 5'd14;
    localparam alu_sel_t ALU_ANDI  = 5'd15;
    localparam alu_sel_t ALU_ORI   = 5'd16;
    localparam alu_sel_t ALU_XORI  = 5'd17;
    localparam alu_sel_t ALU_LUI   = 5'd18;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS instruction decoder: maps an instruction word onto the
// ALU select code, immediate usage, writeback register and illegal flag.
module alu_decode
    import mips_alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  sel,
    output logic        use_imm,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        illegal
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic       is_nop_s;
    alu_sel_t   sel_s;
    logic       imm_s;

    assign opcode_s = instr[31:26];
    assign funct_s  = instr[5:0];
    assign is_nop_s = (instr == 32'h0000_0000);

    // Opcode/funct table lookup; unknown encodings fall through to ALU_NOP.
    always_comb begin
        sel_s = ALU_NOP;
        imm_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD:  sel_s = ALU_ADD;
                    FN_ADDU: sel_s = ALU_ADDU;
                    FN_SUB:  sel_s = ALU_SUB;
                    FN_SUBU: sel_s = ALU_SUBU;
                    FN_AND:  sel_s = ALU_AND;
                    FN_OR:   sel_s = ALU_OR;
                    FN_XOR:  sel_s = ALU_XOR;
                    FN_NOR:  sel_s = ALU_NOR;
                    FN_SLT:  sel_s = ALU_SLT;
                    FN_SLTU: sel_s = ALU_SLTU;
                    default: sel_s = ALU_NOP;
                endcase
            end
            OP_ADDI:  begin sel_s = ALU_ADDI;  imm_s = 1'b1; end
            OP_ADDIU: begin sel_s = ALU_ADDIU; imm_s = 1'b1; end
            OP_SLTI:  begin sel_s = ALU_SLTI;  imm_s = 1'b1; end
            OP_SLTIU: begin sel_s = ALU_SLTIU; imm_s = 1'b1; end
            OP_ANDI:  begin sel_s = ALU_ANDI;  imm_s = 1'b1; end
            OP_ORI:   begin sel_s = ALU_ORI;   imm_s = 1'b1; end
            OP_XORI:  begin sel_s = ALU_XORI;  imm_s = 1'b1; end
            OP_LUI:   begin sel_s = ALU_LUI;   imm_s = 1'b1; end
            default:  begin sel_s = ALU_NOP;   imm_s = 1'b0; end
        endcase
    end

    // Classify as NOP / illegal / decoded and derive destination and write enable.
    always_comb begin
        sel       = sel_s;
        use_imm   = imm_s;
        dest_reg  = 5'd0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        if (is_nop_s) begin
            illegal = 1'b0;
        end else if (sel_s == ALU_NOP) begin
            illegal = 1'b1;
        end else begin
            dest_reg  = imm_s ? instr[20:16] : instr[15:11];
            reg_write = (dest_reg != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register driving the ALU sel/A/B interface with valid/ready
// flow control, flush and a saturating illegal-instruction counter.
module alu_issue_stage
    import mips_alu_pkg::*;
#(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          rs_data,
    input  logic [31:0]          rt_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           alu_sel,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [4:0]           dest_reg,
    output logic                 reg_write,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [ILL_CNT_W-1:0] CNT_MAX = {ILL_CNT_W{1'b1}};
    localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    logic [4:0]  dec_sel_s;
    logic        dec_imm_s;
    logic [4:0]  dec_dest_s;
    logic        dec_wr_s;
    logic        dec_ill_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic        accept_s;

    logic                 out_valid_r;
    logic [4:0]           alu_sel_r;
    logic [31:0]          alu_a_r;
    logic [31:0]          alu_b_r;
    logic [4:0]           dest_reg_r;
    logic                 reg_write_r;
    logic                 illegal_r;
    logic [ILL_CNT_W-1:0] ill_count_r;

    alu_decode u_decode (
        .instr     (instr),
        .sel       (dec_sel_s),
        .use_imm   (dec_imm_s),
        .dest_reg  (dec_dest_s),
        .reg_write (dec_wr_s),
        .illegal   (dec_ill_s)
    );

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // Operand selection; NOP and illegal entries carry zero operands.
    always_comb begin
        op_a_s = 32'h0000_0000;
        op_b_s = 32'h0000_0000;
        if (dec_sel_s == ALU_NOP) begin
            op_a_s = 32'h0000_0000;
        end else if (dec_imm_s) begin
            op_a_s = rs_data;
            op_b_s = {{16{instr[15]}}, instr[15:0]};
        end else begin
            op_a_s = rs_data;
            op_b_s = rt_data;
        end
    end

    // Pipeline slot: load on accept, otherwise drop valid on flush or consume.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            alu_sel_r   <= 5'd0;
            alu_a_r     <= 32'h0000_0000;
            alu_b_r     <= 32'h0000_0000;
            dest_reg_r  <= 5'd0;
            reg_write_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            alu_sel_r   <= dec_sel_s;
            alu_a_r     <= op_a_s;
            alu_b_r     <= op_b_s;
            dest_reg_r  <= dec_dest_s;
            reg_write_r <= dec_wr_s;
            illegal_r   <= dec_ill_s;
        end else if (flush || out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of illegal instructions that were actually accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ill_count_r <= {ILL_CNT_W{1'b0}};
        end else if (accept_s && dec_ill_s && (ill_count_r != CNT_MAX)) begin
            ill_count_r <= ill_count_r + CNT_ONE;
        end else begin
            ill_count_r <= ill_count_r;
        end
    end

    assign out_valid = out_valid_r;
    assign alu_sel   = alu_sel_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign dest_reg  = dest_reg_r;
    assign reg_write = reg_write_r;
    assign illegal   = illegal_r;
    assign ill_count = ill_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed plan steps followed by
// randomized traffic, all checked against a behavioural decode/slot model.
module tb_alu_issue_stage;

    localparam int W = 8;
    localparam int CMAX = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, flush, out_ready;
    logic [31:0] instr, rs_data, rt_data;
    wire         in_ready, out_valid, reg_write, illegal;
    wire  [4:0]  alu_sel, dest_reg;
    wire  [31:0] alu_a, alu_b;
    wire  [W-1:0] ill_count;

    always #5 clk = ~clk;

    alu_issue_stage #(.ILL_CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel),
        .alu_a(alu_a), .alu_b(alu_b), .dest_reg(dest_reg), .reg_write(reg_write),
        .illegal(illegal), .ill_count(ill_count)
    );

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        wr;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t held;
    bit   hv;
    int   cnt;
    int   rfun [int];
    logic [5:0] fn_list [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode from the instruction-set table.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        int op, fn;
        e  = '0;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (ins == 32'h0) return e;
        if (op == 0 && rfun.exists(fn)) begin
            e.sel = 5'(rfun[fn]); e.a = rs; e.b = rt; e.dest = ins[15:11];
        end else if (op >= 8 && op <= 15) begin
            e.sel = 5'(op + 3); e.a = rs;
            e.b = 32'(int'($signed(ins[15:0])));
            e.dest = ins[20:16];
        end else begin
            e.ill = 1'b1;
        end
        e.wr = !e.ill && (e.dest != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0:       return 32'h0;
            1, 2, 3: return {6'h00, r[25:6], fn_list[$urandom_range(0, 9)]};
            4, 5, 6: return {6'(8 + $urandom_range(0, 7)), r[25:0]};
            7:       return {6'h3F, r[25:0]};
            8:       return {6'h00, r[25:12], 1'b1, r[10:6], 6'h00};
            default: return r;
        endcase
    endfunction

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic ordy, input logic fl);
        exp_t nx;
        bit acc;
        @(negedge clk);
        reset_n = rst; in_valid = iv; instr = ins; rs_data = rs; rt_data = rt;
        out_ready = ordy; flush = fl;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!hv || ordy)});
        nx = ref_decode(ins, rs, rt);
        @(posedge clk);
        if (!rst) begin
            hv = 1'b0; held = '0; cnt = 0;
        end else begin
            acc = iv && (!hv || ordy) && !fl;
            if (acc) begin
                held = nx; hv = 1'b1;
                if (nx.ill && cnt < CMAX) cnt++;
            end else if (fl || ordy) begin
                hv = 1'b0;
            end
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, hv});
        chk("alu_sel",   {27'd0, alu_sel},   {27'd0, held.sel});
        chk("alu_a",     alu_a,              held.a);
        chk("alu_b",     alu_b,              held.b);
        chk("dest_reg",  {27'd0, dest_reg},  {27'd0, held.dest});
        chk("reg_write", {31'd0, reg_write}, {31'd0, held.wr});
        chk("illegal",   {31'd0, illegal},   {31'd0, held.ill});
        chk("ill_count", 32'(ill_count),     32'(cnt));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rfun[32 + i] = i + 1;
        rfun[42] = 9;
        rfun[43] = 10;
        hv = 1'b0; held = '0; cnt = 0;
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        repeat (2) @(posedge clk);

        // reset state
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // add $3,$1,$2
        step(1'b1, 1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add_sel",  {27'd0, alu_sel}, 32'd1);
        chk("add_a",    alu_a, 32'd5);
        chk("add_b",    alu_b, 32'd7);
        chk("add_dest", {27'd0, dest_reg}, 32'd3);
        chk("add_wr",   {31'd0, reg_write}, 32'd1);

        // addi $4,$1,-1 and ori $5,$1,0x8000
        step(1'b1, 1'b1, 32'h2024FFFF, 32'h11, 32'h0, 1'b1, 1'b0);
        chk("addi_sel",  {27'd0, alu_sel}, 32'd11);
        chk("addi_b",    alu_b, 32'hFFFFFFFF);
        chk("addi_dest", {27'd0, dest_reg}, 32'd4);
        step(1'b1, 1'b1, 32'h34258000, 32'h3, 32'h0, 1'b1, 1'b0);
        chk("ori_sel", {27'd0, alu_sel}, 32'd16);
        chk("ori_b",   alu_b, 32'hFFFF8000);

        // back-pressure: sub waits three cycles, then enters exactly once
        repeat (3) begin
            step(1'b1, 1'b1, 32'h00223822, 32'd9, 32'd4, 1'b0, 1'b0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", {27'd0, alu_sel}, 32'd16);
        end
        step(1'b1, 1'b1, 32'h00223822, 32'd9, 32'd4, 1'b1, 1'b0);
        chk("bp_sub_sel", {27'd0, alu_sel}, 32'd3);
        chk("bp_sub_dest", {27'd0, dest_reg}, 32'd7);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // flush with held valid entry, then flush concurrent with consume
        step(1'b1, 1'b1, 32'hFC000000, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("ill_one", 32'(ill_count), 32'd1);
        step(1'b1, 1'b1, 32'hFC000001, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cnt", 32'(ill_count), 32'd1);
        step(1'b1, 1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hFC000002, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("flush_rdy_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_rdy_cnt", 32'(ill_count), 32'd1);

        // illegal opcode 0x3F issued 300 times
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, {6'h3F, 26'(i)}, $urandom, $urandom, 1'b1, 1'b0);
        chk("ill_sat", 32'(ill_count), 32'd255);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_sel", {27'd0, alu_sel}, 32'd0);
        chk("ill_wr", {31'd0, reg_write}, 32'd0);

        // reset during a stall holding sltu
        step(1'b1, 1'b1, 32'h0022302B, 32'd1, 32'd2, 1'b1, 1'b0);
        chk("sltu_sel", {27'd0, alu_sel}, 32'd10);
        step(1'b1, 1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
        chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_sel", {27'd0, alu_sel}, 32'd0);
        chk("rst_stall_a", alu_a, 32'd0);
        chk("rst_stall_cnt", 32'(ill_count), 32'd0);
        chk("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);

        // addu $0,$1,$2 never writes back
        step(1'b1, 1'b1, 32'h00220021, 32'd3, 32'd4, 1'b1, 1'b0);
        chk("addu0_sel", {27'd0, alu_sel}, 32'd2);
        chk("addu0_wr", {31'd0, reg_write}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 3) != 0),
                 rand_instr(), $urandom, $urandom,
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
